upsample2x_stream: RTL and testbench
====================================

Name: upsample2x_stream

Overview:
- Streaming 2x nearest-neighbour upsampler for the YOLOv5 neck (nn.Upsample, scale 2). It is the expanding counterpart of the pooling max units.
- Accepts one feature-map channel plane, W x H pixels in row-major order, over valid/ready.
- Emits a 2W x 2H plane: every pixel is repeated twice horizontally and every row twice vertically.
- Sits between the conv output buffer and the concat stage. One instance per channel lane.

Parameters:
- DATA_WIDTH, 16: pixel width in bits (fixed-point, passed through untouched).
- MAX_WIDTH, 64: maximum input row width; sets the line-buffer depth.
- DIM_BITS, 7: width of the cfg_width/cfg_height fields and internal counters; must satisfy 2^DIM_BITS > MAX_WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse; latches cfg_width/cfg_height and begins a frame.
- cfg_width, input, DIM_BITS: input row width W.
- cfg_height, input, DIM_BITS: input row count H.
- busy, output, 1: high from accepted start until done.
- done, output, 1: one-cycle pulse after the final output beat is accepted.
- err_cfg, output, 1: one-cycle pulse when start is rejected.
- in_valid, input, 1: input pixel valid.
- in_ready, output, 1: input pixel accepted when in_valid && in_ready.
- in_data, input, DATA_WIDTH: input pixel.
- in_last, input, 1: marks the last pixel of an input row. Used only with the optional feature.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream ready.
- out_data, output, DATA_WIDTH: output pixel.
- out_last, output, 1: high on the last beat (beat 2W) of every output row.
- out_frame_last, output, 1: high on the final beat of the frame.

Behaviour:
- Reset values: busy, done, err_cfg, in_ready, out_valid, out_last and out_frame_last are 0; out_data is 0; state is IDLE; all counters are 0. Line-buffer contents are don't-care.
- Reset mid-frame abandons the frame with no done pulse.
- start is accepted only in IDLE and only when 1 <= W <= MAX_WIDTH and H >= 1.
  - Otherwise err_cfg pulses on the next cycle and the block stays in IDLE.
  - start while busy is ignored silently.
- States:
  - IDLE. On a valid start, go to ROW_A.
  - ROW_A (first copy of a row; consumes input). When the output register is free, in_ready=1 and dup=0.
    - On accept: write pixel to line_buf[col], load out_data, set out_valid and dup=1. in_ready is 0 while dup=1.
    - The next output handshake re-presents the same out_data (the second beat) and clears dup.
    - After the second beat of column W-1, go to ROW_B.
  - ROW_B (second copy; no input, in_ready=0). Replays line_buf[0..W-1], each value on two consecutive beats. line_buf is a register array read combinationally.
    - After the last beat: if row == H-1, go to IDLE and pulse done; otherwise increment row and go to ROW_A.
- Output register holds out_data/out_valid stable while out_valid && !out_ready.
  - Beats may be issued back-to-back at one per cycle when out_ready is held high.
- Latency: first out_valid is the cycle after the first input accept.
- Steady-state throughput:
  - ROW_A: 1 input per 2 cycles, 1 output per cycle.
  - ROW_B: 1 output per cycle.
  - Total 4WH output beats per frame.
- out_last asserts when the horizontal beat counter equals 2W-1, in both ROW_A and ROW_B.
- out_frame_last = out_last && ROW_B && row == H-1.
- Edge case W=1: each row yields 2 beats in ROW_A, then 2 in ROW_B.
- Edge case H=1: a single ROW_A/ROW_B pair.
- done is not asserted before the final beat's handshake.
- Counters never wrap: col counts 0..W-1, row counts 0..H-1, both reset on start.

Optional Feature:
- Macro UPSAMPLE2X_ROWCHK_EN.
- Defined:
  - Adds output err_row (1 bit, reset 0, sticky until the next accepted start).
  - Sets err_row when an accepted pixel has in_last != (col == W-1).
  - Data flow is unaffected.
- Undefined: in_last is ignored, no err_row port exists, and no check logic is built.

Test Plan:
- W=2, H=2, in = 1,2,3,4, out_ready=1 -> 16 beats: 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4. out_last on beats 4,8,12,16; out_frame_last on beat 16; done pulses the next cycle.
- W=1, H=1, in = 0xABCD -> 4 beats of 0xABCD, out_last on beats 2 and 4, done once.
- W=3, H=2, out_ready toggled randomly -> out_data stable during every stall, order matches the reference model, and in_ready is never high while dup=1 or in ROW_B.
- start with cfg_width=0, then with cfg_width=MAX_WIDTH+1 -> err_cfg pulses each time, busy stays 0, in_ready stays 0.
- Assert rst_n low mid-ROW_B of a W=4, H=4 frame -> all outputs are 0 immediately. A new W=2, H=1 frame then runs correctly.
- With UPSAMPLE2X_ROWCHK_EN, W=3, in_last asserted on the 2nd pixel -> err_row=1 and held; output data is unchanged.

Source files
------------

// File: rtl/upsample2x_stream_if.sv
// Stream bus for upsample2x_stream: pixel input channel and upsampled output channel.
// Valid/ready: a beat transfers on a rising edge where valid && ready; the source holds data stable while valid && !ready.
interface upsample2x_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_frame_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_frame_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_frame_last
    );
endinterface

// File: rtl/upsample2x_stream.sv
// Streaming 2x nearest-neighbour upsampler: each pixel emitted twice, each row replayed from a line buffer.
// Optional row-length check (err_row port) is built when UPSAMPLE2X_ROWCHK_EN is defined.
module upsample2x_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WIDTH  = 64,
    parameter int DIM_BITS   = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DIM_BITS-1:0] cfg_width,
    input  logic [DIM_BITS-1:0] cfg_height,
    output logic                busy,
    output logic                done,
    output logic                err_cfg,
`ifdef UPSAMPLE2X_ROWCHK_EN
    output logic                err_row,
`endif
    output logic [1:0]          dbg_state,
    output logic                dbg_dup,
    upsample2x_stream_if.slave  bus
);
    localparam int IDX_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int HC_W  = DIM_BITS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW_A = 2'd1,
        ROW_B = 2'd2
    } state_t;

    state_t                state;
    logic [DIM_BITS-1:0]   w_last;
    logic [DIM_BITS-1:0]   h_last;
    logic [DIM_BITS-1:0]   col;
    logic [DIM_BITS-1:0]   row;
    logic [HC_W-1:0]       hcnt;
    logic                  dup;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  last_reg;
    logic                  frame_last_reg;
    logic [DATA_WIDTH-1:0] line_buf [MAX_WIDTH];

    logic                  out_fire;
    logic                  col_full;
    logic                  in_ready_c;
    logic                  in_fire;
    logic [DIM_BITS-1:0]   wr_col;
    logic [HC_W-1:0]       hcnt_inc;
    logic [HC_W-1:0]       w2m1;
    logic                  cfg_ok;

    assign out_fire = valid_reg && bus.out_ready;
    assign col_full = (col == w_last);
    // A new pixel may enter only once the second copy of the previous one leaves, and never past the row end.
    assign in_ready_c = (state == ROW_A) && !dup && (!valid_reg || (bus.out_ready && !col_full));
    assign in_fire  = bus.in_valid && in_ready_c;
    assign wr_col   = valid_reg ? col + 1'b1 : col;
    assign hcnt_inc = hcnt + 1'b1;
    assign w2m1     = {w_last, 1'b1};
    assign cfg_ok   = (cfg_width != '0) && (cfg_width <= DIM_BITS'(MAX_WIDTH)) && (cfg_height != '0);

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = valid_reg;
    assign bus.out_data       = data_reg;
    assign bus.out_last       = last_reg;
    assign bus.out_frame_last = frame_last_reg;
    assign dbg_state          = state;
    assign dbg_dup            = dup;

    always_ff @(posedge clk) begin
        if (in_fire) begin
            line_buf[wr_col[IDX_W-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            w_last         <= '0;
            h_last         <= '0;
            col            <= '0;
            row            <= '0;
            hcnt           <= '0;
            dup            <= 1'b0;
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            last_reg       <= 1'b0;
            frame_last_reg <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cfg        <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_last <= cfg_width - 1'b1;
                            h_last <= cfg_height - 1'b1;
                            col    <= '0;
                            row    <= '0;
                            hcnt   <= '0;
                            dup    <= 1'b0;
                            busy   <= 1'b1;
                            state  <= ROW_A;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                ROW_A: begin
                    if (out_fire && dup) begin
                        dup      <= 1'b0;
                        hcnt     <= hcnt_inc;
                        last_reg <= (hcnt_inc == w2m1);
                    end else begin
                        if (out_fire) begin
                            last_reg <= 1'b0;
                            if (col_full) begin
                                // Start the replay on the same cycle so rows stream without a bubble.
                                state    <= ROW_B;
                                data_reg <= line_buf[0];
                                hcnt     <= '0;
                                col      <= '0;
                            end else begin
                                col       <= col + 1'b1;
                                valid_reg <= 1'b0;
                            end
                        end
                        if (in_fire) begin
                            data_reg  <= bus.in_data;
                            valid_reg <= 1'b1;
                            dup       <= 1'b1;
                            hcnt      <= {wr_col, 1'b0};
                            last_reg  <= 1'b0;
                        end
                    end
                end
                ROW_B: begin
                    if (out_fire) begin
                        if (last_reg) begin
                            valid_reg      <= 1'b0;
                            last_reg       <= 1'b0;
                            frame_last_reg <= 1'b0;
                            hcnt           <= '0;
                            if (row == h_last) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                row   <= row + 1'b1;
                                state <= ROW_A;
                            end
                        end else begin
                            hcnt           <= hcnt_inc;
                            data_reg       <= line_buf[hcnt_inc[IDX_W:1]];
                            last_reg       <= (hcnt_inc == w2m1);
                            frame_last_reg <= (hcnt_inc == w2m1) && (row == h_last);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UPSAMPLE2X_ROWCHK_EN
    // Sticky flag: the upstream row marker disagrees with the configured width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_row <= 1'b0;
        end else if ((state == IDLE) && start && cfg_ok) begin
            err_row <= 1'b0;
        end else if (in_fire && (bus.in_last != (wr_col == w_last))) begin
            err_row <= 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
`endif
endmodule

// File: tb/tb_upsample2x_stream.sv
// Self-checking bench for upsample2x_stream: directed frames, scoreboard of expected output beats.
module tb_upsample2x_stream;
  localparam int DW   = 16;
  localparam int MAXW = 64;
  localparam int DB   = 7;
  localparam int EW   = DW + 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROW_B = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DB-1:0] cfg_width = '0;
  logic [DB-1:0] cfg_height = '0;
  logic          busy;
  logic          done;
  logic          err_cfg;
  logic [1:0]    dbg_state;
  logic          dbg_dup;
`ifdef UPSAMPLE2X_ROWCHK_EN
  logic          err_row;
`endif

  upsample2x_stream_if #(.DATA_WIDTH(DW)) bus ();

  upsample2x_stream #(
    .DATA_WIDTH(DW),
    .MAX_WIDTH (MAXW),
    .DIM_BITS  (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .busy      (busy),
    .done      (done),
    .err_cfg   (err_cfg),
`ifdef UPSAMPLE2X_ROWCHK_EN
    .err_row   (err_row),
`endif
    .dbg_state (dbg_state),
    .dbg_dup   (dbg_dup),
    .bus       (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  bit rnd_ready = 1'b0;
  bit stalled_prev = 1'b0;
  logic [EW:0]    held;
  logic [EW-1:0]  mon_exp;
  logic [EW-1:0]  exp_q[$];
  logic [DW-1:0]  pix[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // downstream ready: always high, or random backpressure
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // scoreboard / protocol monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev)
        check("stall_hold", {bus.out_valid, bus.out_frame_last, bus.out_last, bus.out_data}, held);
      if (bus.out_valid && bus.out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("beat", {bus.out_frame_last, bus.out_last, bus.out_data}, mon_exp);
        end
      end
      if (dbg_dup || dbg_state == ST_ROW_B)
        check("in_ready_blocked", bus.in_ready, 0);
      if (done) begin
        done_cnt++;
        check("done_after_last", exp_q.size() == 0, 1);
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_valid, bus.out_frame_last, bus.out_last, bus.out_data};
    end
  end

  // driver tasks (all start and end at posedge + 1)
  task automatic build_frame(input int w, input int h, input int mode);
    logic lst, fl;
    pix.delete();
    for (int i = 0; i < w * h; i++) begin
      case (mode)
        0:       pix.push_back(DW'(i + 1));
        1:       pix.push_back(16'hABCD);
        default: pix.push_back(DW'($urandom_range(0, 65535)));
      endcase
    end
    for (int r = 0; r < h; r++)
      for (int cp = 0; cp < 2; cp++)
        for (int c = 0; c < w; c++)
          for (int k = 0; k < 2; k++) begin
            lst = ((2 * c + k) == (2 * w - 1));
            fl  = lst && (cp == 1) && (r == h - 1);
            exp_q.push_back({fl, lst, pix[r * w + c]});
          end
  endtask

  task automatic start_frame(input int w, input int h);
    done_cnt = 0;
    start = 1'b1;
    cfg_width = DB'(w);
    cfg_height = DB'(h);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_pixel(input logic [DW-1:0] d, input logic last);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = last;
    for (int n = 0; n < 400 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    check("in_accept", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done_once", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input int bad_idx);
    build_frame(w, h, mode);
    start_frame(w, h);
    for (int i = 0; i < w * h; i++) begin
      send_pixel(pix[i], ((i % w) == w - 1) != (i == bad_idx));
      if (i == 0) check("first_out_latency", bus.out_valid, 1);
    end
    wait_done();
  endtask

  task automatic bad_start(input int w, input int h);
    start = 1'b1;
    cfg_width = DB'(w);
    cfg_height = DB'(h);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("err_cfg_pulse", err_cfg, 1);
    check("err_cfg_busy", busy, 0);
    check("err_cfg_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("err_cfg_clear", err_cfg, 0);
    check("err_cfg_idle", dbg_state, ST_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cfg", err_cfg, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_frame_last", bus.out_frame_last, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // W=2 H=2 sequential data, full throughput
    run_frame(2, 2, 0, -1);
    // W=1 H=1 single pixel
    run_frame(1, 1, 1, -1);
    // W=3 H=2 random data under random backpressure
    rnd_ready = 1'b1;
    run_frame(3, 2, 2, -1);
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // rejected configurations
    bad_start(0, 2);
    bad_start(MAXW + 1, 2);
    bad_start(2, 0);

    // reset in the middle of a replayed row
    build_frame(4, 4, 2);
    start_frame(4, 4);
    for (int i = 0; i < 4; i++) send_pixel(pix[i], i == 3);
    for (int n = 0; n < 100 && dbg_state != ST_ROW_B; n++) @(negedge clk);
    check("reach_row_b", dbg_state, ST_ROW_B);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_last", bus.out_last, 0);
    check("midrst_frame_last", bus.out_frame_last, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    run_frame(2, 1, 0, -1);

`ifdef UPSAMPLE2X_ROWCHK_EN
    run_frame(3, 1, 0, 1);
    check("err_row_set", err_row, 1);
    repeat (5) @(posedge clk);
    #1;
    check("err_row_held", err_row, 1);
    run_frame(2, 1, 2, -1);
    check("err_row_cleared", err_row, 0);
`endif

    // widest row under backpressure
    rnd_ready = 1'b1;
    run_frame(MAXW, 1, 2, -1);
    rnd_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
